// File: rtl/sprite_engine_multi.sv
// Sprite overlay video generator: NUM_SPR 8x8 one-bit sprites, scaled, on a VGA-style raster.
// Latency: uo_out reflects the counter position held one clock earlier; register reads are combinational.
// Backpressure: none; data_ready is tied high and every access completes in the cycle it is presented.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   ui_in                 unused input
//   uo_out                registered {vsync, hsync, B[1:0], G[1:0], R[1:0]}
//   address               byte address into the register space
//   data_in               write data
//   data_write_n          11 idle, 00 8-bit, 01 16-bit, 10 32-bit write
//   data_read_n           11 idle, anything else reads
//   data_out              combinational, zero-extended read data
//   data_ready            always 1
//   user_interrupt        frame interrupt flag
module sprite_engine_multi #(
  parameter int NUM_SPR    = 4,
  parameter int SCALE_LOG2 = 2,
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // Control / status
  logic        stream_en;
  logic        irq_en;
  logic        irq_flag;
  logic [15:0] frame_cnt;

  // Staging set: what the CPU writes and reads back
  logic [7:0]  stg_x   [NUM_SPR];
  logic [7:0]  stg_y   [NUM_SPR];
  logic        stg_en  [NUM_SPR];
  logic [5:0]  stg_col [NUM_SPR];
  logic [63:0] stg_bmp [NUM_SPR];

  // Active set: what the raster actually draws
  logic [7:0]  act_x   [NUM_SPR];
  logic [7:0]  act_y   [NUM_SPR];
  logic        act_en  [NUM_SPR];
  logic [5:0]  act_col [NUM_SPR];
  logic [63:0] act_bmp [NUM_SPR];

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic       wr_any;
  logic       wr16;
  logic       ctrl_wr;
  logic       hsync_c;
  logic       vsync_c;
  logic       vsync_rise;
  logic       active_c;
  logic [8:0] lx;
  logic [8:0] ly;
  logic [8:0] dx;
  logic [8:0] dy;
  logic [5:0] rgb;

  logic unused_ok;
  assign unused_ok = ^{ui_in, data_in[31:16]};

  assign data_ready     = 1'b1;
  assign user_interrupt = irq_flag;

  assign wr_any  = (data_write_n != 2'b11);
  assign wr16    = (data_write_n == 2'b01);
  assign ctrl_wr = wr_any && (address == 6'h00);

  // Sync generation is gated by stream_en so an idle block never produces a vsync edge.
  assign hsync_c = stream_en && (int'(h_cnt) >= H_ACTIVE + H_FP)
                             && (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign vsync_c = stream_en && (int'(v_cnt) >= V_ACTIVE + V_FP)
                             && (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
  // uo_out[7] is the registered vsync, so this marks the edge where the output vsync goes high.
  assign vsync_rise = vsync_c && !uo_out[7];
  assign active_c   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);

  assign lx = 9'(h_cnt >> SCALE_LOG2);
  assign ly = 9'(v_cnt >> SCALE_LOG2);

  // Pixel compositor. Walk from the highest index down so the lowest opaque sprite is written last.
  // Offsets are 9-bit differences; a negative offset has upper bits set and so never hits.
  always_comb begin
    rgb = 6'd0;
    dx  = 9'd0;
    dy  = 9'd0;
    for (int n = NUM_SPR - 1; n >= 0; n--) begin
      dx = lx - {1'b0, act_x[n]};
      dy = ly - {1'b0, act_y[n]};
      if (act_en[n] && (dx[8:3] == 6'd0) && (dy[8:3] == 6'd0) &&
          act_bmp[n][{dy[2:0], dx[2:0]}]) begin
        rgb = act_col[n];
      end
    end
    if (!active_c) begin
      rgb = 6'd0;
    end
  end

  // Register read mux
  always_comb begin
    data_out = 32'd0;
    if (data_read_n != 2'b11) begin
      if (address == 6'h00) data_out = {29'd0, irq_flag, irq_en, stream_en};
      if (address == 6'h02) data_out = {16'd0, frame_cnt};
      for (int n = 0; n < NUM_SPR; n++) begin
        if (address == 6'(4 + 12 * n))  data_out = {16'd0, stg_y[n], stg_x[n]};
        if (address == 6'(6 + 12 * n))  data_out = {23'd0, stg_en[n], 2'd0, stg_col[n]};
        if (address == 6'(8 + 12 * n))  data_out = {16'd0, stg_bmp[n][15:0]};
        if (address == 6'(10 + 12 * n)) data_out = {16'd0, stg_bmp[n][31:16]};
        if (address == 6'(12 + 12 * n)) data_out = {16'd0, stg_bmp[n][47:32]};
        if (address == 6'(14 + 12 * n)) data_out = {16'd0, stg_bmp[n][63:48]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream_en <= 1'b0;
      irq_en    <= 1'b0;
      irq_flag  <= 1'b0;
      frame_cnt <= 16'd0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      uo_out    <= 8'd0;
      for (int n = 0; n < NUM_SPR; n++) begin
        stg_x[n]   <= 8'd0;
        stg_y[n]   <= 8'd0;
        stg_en[n]  <= 1'b0;
        stg_col[n] <= 6'd0;
        stg_bmp[n] <= 64'd0;
        act_x[n]   <= 8'd0;
        act_y[n]   <= 8'd0;
        act_en[n]  <= 1'b0;
        act_col[n] <= 6'd0;
        act_bmp[n] <= 64'd0;
      end
    end else begin
      if (ctrl_wr) begin
        stream_en <= data_in[0];
        irq_en    <= data_in[1];
      end

      // A frame event beats a coincident write-1-to-clear.
      if (vsync_rise && irq_en) begin
        irq_flag <= 1'b1;
      end else if (ctrl_wr && data_in[2]) begin
        irq_flag <= 1'b0;
      end

      if (vsync_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      for (int n = 0; n < NUM_SPR; n++) begin
        if (wr16) begin
          if (address == 6'(4 + 12 * n)) begin
            stg_x[n] <= data_in[7:0];
            stg_y[n] <= data_in[15:8];
          end
          if (address == 6'(6 + 12 * n)) begin
            stg_en[n]  <= data_in[8];
            stg_col[n] <= data_in[5:0];
          end
          if (address == 6'(8 + 12 * n))  stg_bmp[n][15:0]  <= data_in[15:0];
          if (address == 6'(10 + 12 * n)) stg_bmp[n][31:16] <= data_in[15:0];
          if (address == 6'(12 + 12 * n)) stg_bmp[n][47:32] <= data_in[15:0];
          if (address == 6'(14 + 12 * n)) stg_bmp[n][63:48] <= data_in[15:0];
        end
        // Copy samples the pre-edge staging value, so a same-cycle write lands in the next copy.
        if (!stream_en || vsync_rise) begin
          act_x[n]   <= stg_x[n];
          act_y[n]   <= stg_y[n];
          act_en[n]  <= stg_en[n];
          act_col[n] <= stg_col[n];
          act_bmp[n] <= stg_bmp[n];
        end
      end

      if (!stream_en) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_cnt == HW'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      uo_out <= stream_en ? {vsync_c, hsync_c, rgb} : 8'd0;
    end
  end

endmodule

// File: tb/tb_sprite_engine_multi.sv
// Directed bench for sprite_engine_multi using a reduced raster:
// 112 clocks per line (hsync at h 100..107), 102 lines per frame (vsync at v 98..99), 4x scaling.
// Pixel index k = v*112 + h is visible on uo_out one clock after the counter held it.
module tb_sprite_engine_multi;

  localparam int HT = 112;
  localparam int FR = 112 * 102;
  localparam int VS_K = 98 * 112;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  sprite_engine_multi #(
    .NUM_SPR(4), .SCALE_LOG2(2),
    .H_ACTIVE(96), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(96), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .address(address),
    .data_in(data_in),
    .data_write_n(data_write_n),
    .data_read_n(data_read_n),
    .data_out(data_out),
    .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address = a;
    data_in = d;
    data_write_n = sz;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    data_read_n = 2'b00;
    #1;
    chk(tag, data_out, exp);
    data_read_n = 2'b11;
  endtask

  // Enabling the stream: the counter holds (0,0) from the capturing edge, numbered t0.
  task automatic start_stream(input logic [31:0] ctrl);
    t0 = cyc + 1;
    wr(6'h00, ctrl, 2'b01);
  endtask

  task automatic goto_pix(input int k);
    while (cyc < t0 + 1 + k) @(negedge clk);
    chk("sched", cyc, t0 + 1 + k);
  endtask

  task automatic pix_chk(input string tag, input int k, input logic [7:0] exp);
    goto_pix(k);
    chk(tag, {24'd0, uo_out}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    ui_in = 8'h00;
    address = 6'h00;
    data_in = 32'd0;
    data_write_n = 2'b11;
    data_read_n = 2'b11;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_uo", {24'd0, uo_out}, 32'd0);
    chk("rst_irq", {31'd0, user_interrupt}, 32'd0);
    chk("ready", {31'd0, data_ready}, 32'd1);
    rst = 1'b0;
    rd_chk("rst_ctrl", 6'h00, 32'd0);
    rd_chk("rst_fcnt", 6'h02, 32'd0);
    rd_chk("rst_spr", 6'h06, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_uo", {24'd0, uo_out}, 32'd0);

    // Single-pixel sprite at the origin
    wr(6'h04, 32'h0000, 2'b01);
    wr(6'h06, 32'h013F, 2'b01);
    wr(6'h08, 32'h0001, 2'b01);
    wr(6'h0A, 32'h0000, 2'b01);
    wr(6'h0C, 32'h0000, 2'b01);
    wr(6'h0E, 32'h0000, 2'b01);
    rd_chk("rb_attr", 6'h06, 32'h013F);
    start_stream(32'h1);
    pix_chk("o_h0v0", 0, 8'h3F);
    pix_chk("o_h3v0", 3, 8'h3F);
    pix_chk("o_h4v0", 4, 8'h00);
    pix_chk("hs_99", 99, 8'h00);
    pix_chk("hs_100", 100, 8'h40);
    pix_chk("hs_107", 107, 8'h40);
    pix_chk("hs_108", 108, 8'h00);
    pix_chk("o_h3v3", 3 * HT + 3, 8'h3F);
    pix_chk("o_h0v4", 4 * HT, 8'h00);
    pix_chk("vs_97", 97 * HT, 8'h00);
    pix_chk("vs_98", VS_K, 8'h80);
    chk("no_irq", {31'd0, user_interrupt}, 32'd0);
    pix_chk("vs_hs", VS_K + 100, 8'hC0);
    pix_chk("vs_100", 100 * HT, 8'h00);
    rd_chk("fcnt1", 6'h02, 32'd1);

    // Stop, reprogram two overlapping sprites, restart
    wr(6'h00, 32'h0, 2'b01);
    @(negedge clk);
    chk("stop_uo", {24'd0, uo_out}, 32'd0);
    wr(6'h04, 32'h0A0A, 2'b01);
    wr(6'h06, 32'h0103, 2'b01);
    for (int i = 0; i < 4; i++) wr(6'(8 + 2 * i), 32'hFFFF, 2'b01);
    wr(6'h10, 32'h0C0C, 2'b01);
    wr(6'h12, 32'h010C, 2'b01);
    for (int i = 0; i < 4; i++) wr(6'(20 + 2 * i), 32'hFFFF, 2'b01);
    start_stream(32'h1);
    pix_chk("b_39_40", 40 * HT + 39, 8'h00);
    pix_chk("b_40_40", 40 * HT + 40, 8'h03);
    pix_chk("b_44_40", 40 * HT + 44, 8'h03);

    // Move sprite 0 mid-frame: current frame keeps the old position
    wr(6'h04, 32'h0A14, 2'b01);
    rd_chk("rb_x20", 6'h04, 32'h0A14);
    pix_chk("ovl_48", 48 * HT + 48, 8'h03);
    pix_chk("ovl_68", 68 * HT + 68, 8'h03);
    pix_chk("s1_72", 72 * HT + 72, 8'h0C);
    pix_chk("s1_79", 79 * HT + 79, 8'h0C);
    pix_chk("s1_80", 80 * HT + 80, 8'h00);
    pix_chk("n_40_40", FR + 40 * HT + 40, 8'h00);
    pix_chk("n_80_40", FR + 40 * HT + 80, 8'h03);
    pix_chk("n_68_68", FR + 68 * HT + 68, 8'h0C);
    rd_chk("fcnt2", 6'h02, 32'd2);

    // Frame interrupt
    wr(6'h00, 32'h3, 2'b10);
    rd_chk("ctrl3", 6'h00, 32'h3);
    chk("irq_pre", {31'd0, user_interrupt}, 32'd0);
    pix_chk("irq_vs", FR + VS_K, 8'h80);
    chk("irq_set", {31'd0, user_interrupt}, 32'd1);
    rd_chk("ctrl7", 6'h00, 32'h7);
    rd_chk("fcnt3", 6'h02, 32'd3);
    wr(6'h00, 32'h7, 2'b00);
    chk("irq_clr", {31'd0, user_interrupt}, 32'd0);
    rd_chk("ctrl_clr", 6'h00, 32'h3);
    goto_pix(2 * FR + VS_K - 1);
    wr(6'h00, 32'h7, 2'b01);
    chk("w1c_vs", {24'd0, uo_out}, 32'h80);
    chk("set_wins", {31'd0, user_interrupt}, 32'd1);
    rd_chk("fcnt4", 6'h02, 32'd4);

    // Ignored writes
    wr(6'h04, 32'h0000FFFF, 2'b00);
    rd_chk("w8_ign", 6'h04, 32'h0A14);
    wr(6'h04, 32'h12345678, 2'b10);
    rd_chk("w32_ign", 6'h04, 32'h0A14);
    wr(6'h3E, 32'hFFFF, 2'b01);
    rd_chk("nospr", 6'h3E, 32'd0);
    rd_chk("odd", 6'h05, 32'd0);

    // Asynchronous reset mid-frame
    pix_chk("pre_rst", 3 * FR + 40 * HT + 80, 8'h03);
    #1 rst = 1'b1;
    #1;
    chk("arst_uo", {24'd0, uo_out}, 32'd0);
    chk("arst_irq", {31'd0, user_interrupt}, 32'd0);
    address = 6'h00;
    data_read_n = 2'b00;
    #1 chk("arst_ctrl", data_out, 32'd0);
    address = 6'h04;
    #1 chk("arst_stg", data_out, 32'd0);
    data_read_n = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_uo", {24'd0, uo_out}, 32'd0);
    rd_chk("post_ctrl", 6'h00, 32'd0);
    rd_chk("post_fcnt", 6'h02, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_engine_multi.md
SPRITE_ENGINE_MULTI -- requirements
Module: sprite_engine_multi

Interface
REQ-001 Parameter NUM_SPR, default 4, sprite count, legal range 1..5.
REQ-002 Parameter SCALE_LOG2, default 2, physical-to-logical pixel shift; each logical pixel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 physical pixels.
REQ-003 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 1024/24/136/160, horizontal timing in clocks.
REQ-004 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 768/3/6/29, vertical timing in lines.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 ui_in  in  8  unused; tie off.
REQ-008 uo_out  out  8  {vsync, hsync, B[1:0], G[1:0], R[1:0]}, registered.
REQ-009 address  in  6  byte address in the peripheral space.
REQ-010 data_in  in  32  write data.
REQ-011 data_write_n  in  2  11 none, 00 8-bit, 01 16-bit, 10 32-bit.
REQ-012 data_read_n  in  2  11 none, else read; size ignored.
REQ-013 data_out  out  32  combinational read data, zero-extended.
REQ-014 data_ready  out  1  constant 1.
REQ-015 user_interrupt  out  1  equals irq_flag.

Function
REQ-016 Register map: 0x00 CONTROL; 0x02 FRAME_CNT (read-only, 16 bit); sprite n base B=0x04+12n: B+0 {y[15:8],x[7:0]}, B+2 {en[8],color[5:0]} with color as {B,G,R} 2 bits each, B+4/6/8/10 bitmap bits [15:0]/[31:16]/[47:32]/[63:48].
REQ-017 CONTROL: bit0 stream_en, bit1 irq_en, both R/W; bit2 reads irq_flag and is write-1-to-clear; any write size to 0x00 is accepted.
REQ-018 Sprite registers accept only 16-bit writes; 8/32-bit writes and writes to unmapped or sprite-index >= NUM_SPR addresses are ignored and read 0.
REQ-019 Sprite writes always go to a staging set, regardless of stream_en; reads return staging values.
REQ-020 The active set is copied from staging in the cycle vsync output rises, and every cycle while stream_en=0.
REQ-021 A staging write in the same cycle as the copy is included in the next copy, not the current one.
REQ-022 h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments at h wrap, 0..V_TOTAL-1 and wraps (H_TOTAL, V_TOTAL = sums of their timing parameters).
REQ-023 stream_en=0 holds h_cnt=v_cnt=0 and drives uo_out=0; 0->1 restarts from (0,0).
REQ-024 hsync is high for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync is high for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); both active-high.
REQ-025 Logical pixel: lx = h_cnt>>SCALE_LOG2, ly = v_cnt>>SCALE_LOG2.
REQ-026 Sprite n hits when en=1, lx-x in [0,7] and ly-y in [0,7], compared at 9 bits; no wrap (x=252 draws logical columns 252..255 only).
REQ-027 Hit bit = bitmap[{ly-y[2:0], lx-x[2:0]}]; pixel opaque when hit bit=1.
REQ-028 Priority: lowest opaque sprite index wins; RGB = its color; no opaque sprite or outside active area gives RGB=0.
REQ-029 Latency: uo_out for counter (h,v) appears exactly 1 clock after the counter holds (h,v); sync and RGB are aligned.
REQ-030 FRAME_CNT increments at each vsync rising edge, wraps 0xFFFF->0.
REQ-031 irq_flag sets on vsync rising edge when irq_en=1; set wins over a simultaneous W1C.

Reset
REQ-032 rst asserted: all registers 0 immediately (CONTROL, FRAME_CNT, staging, active, counters, irq_flag); uo_out=0, user_interrupt=0.
REQ-033 rst mid-frame aborts the frame; after release the block stays idle until stream_en is written to 1.

Verification
REQ-034 Sprite 0 x=0,y=0,en=1,color=0x3F,bitmap=0x1 with default parameters, stream_en=1 -> uo_out[5:0]=0x3F for h_cnt 0..3, v 0..3; 0 at h=4.
REQ-035 Sprites 0 and 1 overlap at (10,10), colors 0x03 and 0x0C, both bitmaps all-ones -> overlap pixels show 0x03.
REQ-036 Write sprite 0 x=20 mid-frame -> current frame still draws at old x; next frame draws at x=20.
REQ-037 irq_en=1, run to vsync rise -> user_interrupt=1 and FRAME_CNT=1; write CONTROL 0x07 -> flag clears; a W1C coincident with the next vsync rise leaves flag=1.
REQ-038 8-bit write to 0x04 and 16-bit write to 0x3E (NUM_SPR=4) -> no change; readback unchanged and 0.
REQ-039 Assert rst at h=500, v=300 -> uo_out=0 and registers 0 without a clock edge; stream_en=0 after release.
